// File: rtl/csram_arbiter_if.sv
// Request/response port between a CSRAM requester (debug bridge or DMA) and
// the arbiter. Signal suffixes are from the arbiter's point of view.
interface csram_arbiter_if;
  logic        req_i;
  logic        lock_i;
  logic [3:0]  we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, lock_i, we_i, addr_i, wdata_i,
    input  ready_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, lock_i, we_i, addr_i, wdata_i,
    output ready_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/csram_arbiter.sv
// Two-port CSRAM arbiter: debug port (p0) and DMA port (p1) share one
// single-port SRAM with 1-cycle read latency. Supports debug priority,
// burst locking, starvation protection and out-of-range error responses.
module csram_arbiter #(
  parameter int unsigned AW       = 12,
  parameter int unsigned MAX_WAIT = 8,
  parameter logic [31:0] ERR_DATA = 32'hDEADDEAD
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           dbg_en_i,
  csram_arbiter_if.slave p0,
  csram_arbiter_if.slave p1,
  output logic           sram_cs_o,
  output logic [3:0]     sram_wren_o,
  output logic [AW-3:0]  sram_addr_o,
  output logic [31:0]    sram_wdata_o,
  input  logic [31:0]    sram_rdata_i
);

  localparam int unsigned SW = $clog2(MAX_WAIT + 1);

  logic          rr_last_q, rr_last_d;
  logic          lock_valid_q, lock_valid_d;
  logic          lock_owner_q, lock_owner_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_owner_q, rsp_owner_d;
  logic          rsp_read_q, rsp_read_d;
  logic          rsp_err_q, rsp_err_d;

  logic          gnt_valid;
  logic          gnt_port;
  logic          starved;
  logic          sel_lock;
  logic [3:0]    sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic          sel_oor;
  logic [31:0]   rsp_data;
  logic          unused_addr_lsb;

  assign starved = (starve_cnt_q == SW'(MAX_WAIT));

  // Grant selection: lock, then debug priority / starvation, then round-robin
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = 1'b0;
    if (rst_i) begin
      if (lock_valid_q && (lock_owner_q ? p1.req_i : p0.req_i)) begin
        gnt_valid = 1'b1;
        gnt_port  = lock_owner_q;
      end else if (p0.req_i && p1.req_i) begin
        gnt_valid = 1'b1;
        gnt_port  = dbg_en_i ? starved : ~rr_last_q;
      end else if (p0.req_i) begin
        gnt_valid = 1'b1;
        gnt_port  = 1'b0;
      end else if (p1.req_i) begin
        gnt_valid = 1'b1;
        gnt_port  = 1'b1;
      end
    end
  end

  // Request mux; port 0 drives the SRAM bus when nobody is granted
  always_comb begin
    sel_lock  = p0.lock_i;
    sel_we    = p0.we_i;
    sel_addr  = p0.addr_i;
    sel_wdata = p0.wdata_i;
    if (gnt_valid && gnt_port) begin
      sel_lock  = p1.lock_i;
      sel_we    = p1.we_i;
      sel_addr  = p1.addr_i;
      sel_wdata = p1.wdata_i;
    end
    sel_oor = |sel_addr[31:AW];
  end

  assign unused_addr_lsb = ^sel_addr[1:0];

  // Next-state: round-robin pointer, lock, starvation counter, response
  always_comb begin
    rr_last_d    = rr_last_q;
    lock_valid_d = 1'b0;
    lock_owner_d = lock_owner_q;
    starve_cnt_d = '0;
    rsp_valid_d  = gnt_valid;
    rsp_owner_d  = gnt_port;
    rsp_read_d   = (sel_we == 4'h0);
    rsp_err_d    = sel_oor;
    if (gnt_valid) begin
      rr_last_d    = gnt_port;
      lock_valid_d = sel_lock;
      lock_owner_d = gnt_port;
    end
    if (dbg_en_i && p1.req_i && !(gnt_valid && gnt_port)) begin
      starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + SW'(1);
    end
  end

  // Outputs: handshake, SRAM drive and response data
  always_comb begin
    p0.ready_o   = gnt_valid & ~gnt_port;
    p1.ready_o   = gnt_valid & gnt_port;
    sram_cs_o    = gnt_valid & ~sel_oor;
    sram_wren_o  = (gnt_valid && !sel_oor) ? sel_we : 4'h0;
    sram_addr_o  = sel_addr[AW-1:2];
    sram_wdata_o = sel_wdata;
    rsp_data     = rsp_err_q ? ERR_DATA : (rsp_read_q ? sram_rdata_i : 32'h0);
    p0.rvalid_o  = rsp_valid_q & ~rsp_owner_q;
    p1.rvalid_o  = rsp_valid_q & rsp_owner_q;
    p0.err_o     = rsp_valid_q & ~rsp_owner_q & rsp_err_q;
    p1.err_o     = rsp_valid_q & rsp_owner_q & rsp_err_q;
    p0.rdata_o   = (rsp_valid_q && !rsp_owner_q) ? rsp_data : 32'h0;
    p1.rdata_o   = (rsp_valid_q && rsp_owner_q) ? rsp_data : 32'h0;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rr_last_q    <= 1'b1;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      starve_cnt_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_owner_q  <= 1'b0;
      rsp_read_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      rr_last_q    <= rr_last_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      starve_cnt_q <= starve_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_owner_q  <= rsp_owner_d;
      rsp_read_q   <= rsp_read_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_csram_arbiter.sv
// Scoreboard bench for csram_arbiter: directed stimulus pushes hand-computed
// responses; a negedge monitor pops and compares on every rvalid.
module tb_csram_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        dbg_en_i = 1'b1;
  logic        sram_cs_o;
  logic [3:0]  sram_wren_o;
  logic [9:0]  sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata_i = 32'h0;
  logic [31:0] mem [0:1023];

  rsp_t q0[$];
  rsp_t q1[$];
  rsp_t m0, m1;
  int   n_pass = 0;
  int   n_total = 0;

  csram_arbiter_if p0_if ();
  csram_arbiter_if p1_if ();

  csram_arbiter #(.AW(12), .MAX_WAIT(8), .ERR_DATA(32'hDEADDEAD)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .dbg_en_i     (dbg_en_i),
    .p0           (p0_if),
    .p1           (p1_if),
    .sram_cs_o    (sram_cs_o),
    .sram_wren_o  (sram_wren_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural single-port SRAM with byte enables and 1-cycle read latency
  always @(posedge clk_i) begin
    if (sram_cs_o) begin
      if (sram_wren_o == 4'h0) sram_rdata_i <= mem[sram_addr_o];
      else for (int b = 0; b < 4; b++)
        if (sram_wren_o[b]) mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every rvalid must match the oldest expected response of its port
  always @(negedge clk_i) begin
    if (p0_if.rvalid_o) begin
      if (q0.size() == 0) check("p0_unexpected_rvalid", 32'(p0_if.rvalid_o), 32'h0);
      else begin
        m0 = q0.pop_front();
        check("p0_rdata", p0_if.rdata_o, m0.data);
        check("p0_err", 32'(p0_if.err_o), 32'(m0.err));
      end
    end
    if (p1_if.rvalid_o) begin
      if (q1.size() == 0) check("p1_unexpected_rvalid", 32'(p1_if.rvalid_o), 32'h0);
      else begin
        m1 = q1.pop_front();
        check("p1_rdata", p1_if.rdata_o, m1.data);
        check("p1_err", 32'(p1_if.err_o), 32'(m1.err));
      end
    end
  end

  task automatic set_p0(input logic req, input logic lock, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    p0_if.req_i = req; p0_if.lock_i = lock; p0_if.we_i = we;
    p0_if.addr_i = addr; p0_if.wdata_i = wdata;
  endtask

  task automatic set_p1(input logic req, input logic lock, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    p1_if.req_i = req; p1_if.lock_i = lock; p1_if.we_i = we;
    p1_if.addr_i = addr; p1_if.wdata_i = wdata;
  endtask

  // One cycle: check grant and SRAM drive mid-cycle, queue the expected response
  task automatic step(input string name, input logic e0, input logic e1, input logic ecs,
                      input int eaddr, input logic [31:0] edata, input logic eerr,
                      input logic push, input logic rst_after);
    rsp_t r;
    @(negedge clk_i);
    check({name, "_ready"}, {30'd0, p0_if.ready_o, p1_if.ready_o}, {30'd0, e0, e1});
    check({name, "_cs"}, 32'(sram_cs_o), 32'(ecs));
    if (eaddr >= 0) check({name, "_addr"}, 32'(sram_addr_o), 32'(eaddr));
    if (push && (e0 || e1)) begin
      r.data = edata;
      r.err  = eerr;
      if (e1) q1.push_back(r);
      else    q0.push_back(r);
    end
    if (rst_after) rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    set_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;

    // Reset state: requests present but nothing granted
    set_p0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    set_p1(1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
    step("rst", 1'b0, 1'b0, 1'b0, -1, 32'h0, 1'b0, 1'b1, 1'b0);
    check("rst_rvalid0", 32'(p0_if.rvalid_o), 32'h0);
    check("rst_rvalid1", 32'(p1_if.rvalid_o), 32'h0);
    check("rst_rdata0", p0_if.rdata_o, 32'h0);
    check("rst_err1", 32'(p1_if.err_o), 32'h0);
    rst_i = 1'b1;
    set_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Single write then read, plus byte-enable merge from port 1
    set_p0(1'b1, 1'b0, 4'hF, 32'h10, 32'h12345678);
    step("wr0", 1'b1, 1'b0, 1'b1, 4, 32'h0, 1'b0, 1'b1, 1'b0);
    set_p0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    step("rd0", 1'b1, 1'b0, 1'b1, 4, 32'h12345678, 1'b0, 1'b1, 1'b0);
    set_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_p1(1'b1, 1'b0, 4'h3, 32'h10, 32'hAAAABBBB);
    step("wr1_be", 1'b0, 1'b1, 1'b1, 4, 32'h0, 1'b0, 1'b1, 1'b0);
    set_p1(1'b1, 1'b0, 4'h0, 32'h13, 32'h0);
    step("rd1_be", 1'b0, 1'b1, 1'b1, 4, 32'h1234BBBB, 1'b0, 1'b1, 1'b0);

    // Preload words 8 and 9, leaving port 1 as last granted
    set_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_p0(1'b1, 1'b0, 4'hF, 32'h20, 32'h11111111);
    step("pre0", 1'b1, 1'b0, 1'b1, 8, 32'h0, 1'b0, 1'b1, 1'b0);
    set_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_p1(1'b1, 1'b0, 4'hF, 32'h24, 32'h22222222);
    step("pre1", 1'b0, 1'b1, 1'b1, 9, 32'h0, 1'b0, 1'b1, 1'b0);

    // Round-robin with both ports reading continuously
    dbg_en_i = 1'b0;
    set_p0(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    set_p1(1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) step($sformatf("rr%0d", i), 1'b1, 1'b0, 1'b1, 8, 32'h11111111, 1'b0, 1'b1, 1'b0);
      else            step($sformatf("rr%0d", i), 1'b0, 1'b1, 1'b1, 9, 32'h22222222, 1'b0, 1'b1, 1'b0);
    end

    // Debug priority with starvation relief every 9th cycle
    dbg_en_i = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i % 9 == 8) step($sformatf("starve%0d", i), 1'b0, 1'b1, 1'b1, 9, 32'h22222222, 1'b0, 1'b1, 1'b0);
      else            step($sformatf("starve%0d", i), 1'b1, 1'b0, 1'b1, 8, 32'h11111111, 1'b0, 1'b1, 1'b0);
    end
    set_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step("idle", 1'b0, 1'b0, 1'b0, -1, 32'h0, 1'b0, 1'b1, 1'b0);

    // Locked DMA burst holds off debug port until lock drops
    set_p1(1'b1, 1'b1, 4'hF, 32'h40, 32'hC0C0C000);
    step("lk0", 1'b0, 1'b1, 1'b1, 16, 32'h0, 1'b0, 1'b1, 1'b0);
    set_p0(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    set_p1(1'b1, 1'b1, 4'hF, 32'h44, 32'hC0C0C001);
    step("lk1", 1'b0, 1'b1, 1'b1, 17, 32'h0, 1'b0, 1'b1, 1'b0);
    set_p1(1'b1, 1'b1, 4'hF, 32'h48, 32'hC0C0C002);
    step("lk2", 1'b0, 1'b1, 1'b1, 18, 32'h0, 1'b0, 1'b1, 1'b0);
    set_p1(1'b1, 1'b0, 4'hF, 32'h4C, 32'hC0C0C003);
    step("lk3", 1'b0, 1'b1, 1'b1, 19, 32'h0, 1'b0, 1'b1, 1'b0);
    set_p1(1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
    step("lk_p0", 1'b1, 1'b0, 1'b1, 8, 32'h11111111, 1'b0, 1'b1, 1'b0);
    set_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step("lk_rd", 1'b0, 1'b1, 1'b1, 17, 32'hC0C0C001, 1'b0, 1'b1, 1'b0);

    // Out-of-range read and write: no SRAM access, error response
    set_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_p0(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0);
    step("err0", 1'b1, 1'b0, 1'b0, -1, 32'hDEADDEAD, 1'b1, 1'b1, 1'b0);
    set_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_p1(1'b1, 1'b0, 4'hF, 32'h80000010, 32'h55555555);
    step("err1", 1'b0, 1'b1, 1'b0, -1, 32'hDEADDEAD, 1'b1, 1'b1, 1'b0);
    set_p1(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    step("post_err", 1'b0, 1'b1, 1'b1, 4, 32'h1234BBBB, 1'b0, 1'b1, 1'b0);

    // Reset right after an accepted read: response is dropped
    dbg_en_i = 1'b0;
    set_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_p0(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    step("mid_rd", 1'b1, 1'b0, 1'b1, 8, 32'h0, 1'b0, 1'b0, 1'b1);
    set_p1(1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
    @(negedge clk_i);
    check("in_rst_rvalid0", 32'(p0_if.rvalid_o), 32'h0);
    check("in_rst_ready", {30'd0, p0_if.ready_o, p1_if.ready_o}, 32'h0);
    check("in_rst_cs", 32'(sram_cs_o), 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    step("post_rst", 1'b1, 1'b0, 1'b1, 8, 32'h11111111, 1'b0, 1'b1, 1'b0);

    set_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step("drain", 1'b0, 1'b0, 1'b0, -1, 32'h0, 1'b0, 1'b1, 1'b0);
    step("drain2", 1'b0, 1'b0, 1'b0, -1, 32'h0, 1'b0, 1'b1, 1'b0);
    check("q0_empty", 32'(q0.size()), 32'h0);
    check("q1_empty", 32'(q1.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
